lsu_mem_port: RTL

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/cpu_types_pkg.sv | 38 +++
 rtl/lsu_byte_align.sv | 42 ++++
 rtl/lsu_mem_port.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared LSU types: access size encoding, port FSM states and the captured request payload.
package cpu_types;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NLANES = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    mem_size_t       size;
    logic            is_unsigned;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Reserved encoding behaves as a word access.
  function automatic logic [2:0] size_bytes(mem_size_t s);
    case (s)
      MEM_BYTE: size_bytes = 3'd1;
      MEM_HALF: size_bytes = 3'd2;
      default:  size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_align.sv
// Byte-lane steering: write masks/data for both words of an access, and load extract/extend.
module lsu_byte_align
  import cpu_types::*;
(
  input  logic [1:0]      offset,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] word_lo,
  input  logic [XLEN-1:0] word_hi,
  output logic            split_c,
  output logic [3:0]      wbe_lo_c,
  output logic [3:0]      wbe_hi_c,
  output logic [XLEN-1:0] wd_lo_c,
  output logic [XLEN-1:0] wd_hi_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [2:0]        nbytes;
  logic [7:0]        mask8;
  logic [2*XLEN-1:0] wd64;
  logic [XLEN-1:0]   rd_sh;

  // Treat the two words as one 8-lane window; the high half spills into the next word.
  always_comb begin
    nbytes   = size_bytes(size);
    split_c  = (4'(offset) + 4'(nbytes)) > 4'd4;
    mask8    = ((8'd1 << nbytes) - 8'd1) << offset;
    wbe_lo_c = mask8[3:0];
    wbe_hi_c = mask8[7:4];
    wd64     = {32'd0, wdata} << {offset, 3'b000};
    wd_lo_c  = wd64[XLEN-1:0];
    wd_hi_c  = wd64[2*XLEN-1:XLEN];
    rd_sh    = XLEN'({word_hi, word_lo} >> {offset, 3'b000});
    case (size)
      MEM_BYTE: rdata_c = is_unsigned ? {24'd0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
      MEM_HALF: rdata_c = is_unsigned ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default:  rdata_c = rd_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port to a word-wide memory; unaligned accesses that straddle a word take two cycles.
module lsu_mem_port
  import cpu_types::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] mem_a,
  output logic            mem_we,
  output logic [3:0]      mem_wbe,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state, next_state;
  lsu_req_t        req_q;
  logic [XLEN-1:0] word1_q, word2_q;
  logic [XLEN-1:0] word_lo, word_hi, base_a;
  logic            split_c, mem_we_c;
  logic [3:0]      wbe_lo_c, wbe_hi_c;
  logic [XLEN-1:0] wd_lo_c, wd_hi_c, rdata_c;

  // The word being read this cycle bypasses its register so the response can be registered into DONE.
  assign word_lo = (state == ACC1) ? mem_rd : word1_q;
  assign word_hi = (state == ACC2) ? mem_rd : word2_q;
  assign base_a  = {req_q.addr[XLEN-1:2], 2'b00};

  lsu_byte_align u_align (
    .offset      (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .wdata       (req_q.wdata),
    .word_lo     (word_lo),
    .word_hi     (word_hi),
    .split_c     (split_c),
    .wbe_lo_c    (wbe_lo_c),
    .wbe_hi_c    (wbe_hi_c),
    .wd_lo_c     (wd_lo_c),
    .wd_hi_c     (wd_hi_c),
    .rdata_c     (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_a      = '0;
    mem_we_c   = 1'b0;
    mem_wbe    = '0;
    mem_wd     = '0;
    case (state)
      IDLE: if (req_valid) next_state = ACC1;
      ACC1: begin
        mem_a      = base_a;
        next_state = split_c ? ACC2 : DONE;
        if (req_q.we) begin
          mem_we_c = 1'b1;
          mem_wbe  = wbe_lo_c;
          mem_wd   = wd_lo_c;
        end
      end
      ACC2: begin
        mem_a      = base_a + 32'd4;
        next_state = DONE;
        if (req_q.we) begin
          mem_we_c = 1'b1;
          mem_wbe  = wbe_hi_c;
          mem_wd   = wd_hi_c;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Reset must suppress a write at the very edge it is asserted on.
  assign mem_we    = mem_we_c & rst_n;
  assign req_ready = rst_n & (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q      <= '0;
      word1_q    <= '0;
      word2_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        req_q <= '{we: req_we, addr: req_addr, size: mem_size_t'(req_size),
                   is_unsigned: req_unsigned, wdata: req_wdata};
      end
      if (state == ACC1) word1_q <= mem_rd;
      if (state == ACC2) word2_q <= mem_rd;
      resp_valid <= (next_state == DONE);
      resp_rdata <= (next_state == DONE && !req_q.we) ? rdata_c : '0;
    end
  end

endmodule
